r4_qds_const_table: RTL and testbench
=====================================

# r4_qds_const_table

Multi-channel, programmable successor to the radix-4 QDS constants generator. It holds the four negated quotient-digit-selection thresholds (-m[-1], -m[-0], -m[+1], -m[+2]) for every divisor-MSB index in a register table. The table is loaded with the default radix-4 values after reset and can be rewritten at run time. Each channel latches a divisor index through a valid/ready handshake and gets registered, held constants for its divider iteration loop.

## Interface
- `NUM_CH`, default 2: number of independent divider channels (≥1).
- `D_MSB_W`, default 3: divisor index width. Table depth is `DEPTH = 2**D_MSB_W`; must be ≥3.
- `CONST_W`, default 7: constant width (≥7). Values are two's complement, sign-extended from the 7-bit base format.
- `clk` — input, 1 bit: clock. Everything is rising-edge.
- `rst` — input, 1 bit: synchronous, active-high reset.
- `cfg_wr_valid` — input, 1 bit: table write request.
- `cfg_wr_ready` — output, 1 bit: table write accepted.
- `cfg_wr_idx` — input, `D_MSB_W` bits: table row to write.
- `cfg_wr_sel` — input, 2 bits: field to write. 0 = m_neg_1, 1 = m_neg_0, 2 = m_pos_1, 3 = m_pos_2.
- `cfg_wr_data` — input, `CONST_W` bits: new value.
- `req_valid_i` — input, `NUM_CH` bits: per-channel lookup request.
- `req_ready_o` — output, `NUM_CH` bits: per-channel lookup accept.
- `req_d_msbs_i` — input, `NUM_CH*D_MSB_W` bits: per-channel divisor index. Channel c occupies slice [c*D_MSB_W +: D_MSB_W].
- `out_valid_o` — output, `NUM_CH` bits: per-channel constants valid.
- `m_neg_1_o`, `m_neg_0_o`, `m_pos_1_o`, `m_pos_2_o` — outputs, `NUM_CH*CONST_W` bits each: per-channel registered constants.

## Operation
- FSM states: INIT and RUN.
  - Reset forces INIT and clears the row counter.
  - INIT writes one default row per cycle, at rows 0..DEPTH-1.
  - After row DEPTH-1 is written, the FSM moves to RUN and stays there.
- Default row r is the 3-bit default entry `k = r >> (D_MSB_W-3)`, sign-extended to `CONST_W`. Defaults for k = 0..7:
  - m_neg_1: 0011010, 0011110, 0100000, 0100010, 0100110, 0101000, 0101100, 0110000
  - m_neg_0: 0000100, 0000110, 0000110, 0000110, 0000110, 0001000, 0001000, 0001000
  - m_pos_1: 1111100, 1111100, 1111100, 1111100, 1111010, 1111010, 1111010, 1111000
  - m_pos_2: 1101000, 1100100, 1100010, 1100000, 1011100, 1011000, 1010100, 1010100
- Binary point: bit 5/4 boundary for m_neg_1 and m_pos_2; bit 4/3 boundary for m_neg_0 and m_pos_1 (7-bit base).
- `cfg_wr_ready` and all `req_ready_o` bits are 0 in INIT and 1 in RUN.
- Config write: on `cfg_wr_valid & cfg_wr_ready`, the selected field of row `cfg_wr_idx` takes `cfg_wr_data` at the clock edge. The other three fields of that row are unchanged.
- Lookup, channel c: on `req_valid_i[c] & req_ready_o[c]`, the table row `req_d_msbs_i[c]` is read combinationally. All four constants of channel c are registered.
  - `out_valid_o[c]` is set to 1.
  - Outputs are sticky: they hold until the next accepted request on that channel.
- Channels are fully independent. Any number of channels may look up the same or different rows in the same cycle; there is no arbitration.
- Read/write collision (write and lookup to the same row in the same cycle): the lookup returns the old value. The new value is visible to lookups from the next cycle.
- Rewriting a row does not update channels that already latched it. The channel must re-request.

## Timing
- Reset values: all constant outputs 0, `out_valid_o` = 0, `cfg_wr_ready` = 0, `req_ready_o` = 0.
- INIT lasts exactly DEPTH cycles after `rst` deasserts. The ready outputs go to 1 on the following cycle.
- Lookup latency: 1 cycle. Request accepted at edge n gives outputs valid after edge n.
- Throughput: one lookup per channel per cycle, plus one config write per cycle.
- `rst` asserted mid-operation (RUN, or INIT partway through): on the next edge the FSM returns to INIT, all outputs return to reset values, and the table is fully reloaded. Prior config writes are lost.
- Inputs are ignored while `rst` = 1.

## Structure
- Shared package `r4_qds_pkg`:
  - `typedef enum` for the FSM states.
  - `localparam` arrays holding the 8×4 default 7-bit codes.
  - Encoding constants for `cfg_wr_sel`.
  - Function `default_const(sel, k, CONST_W)` that returns the sign-extended default.
- One sub-module, `r4_qds_const_rd_port`: per-channel handshake plus output registers, instantiated `NUM_CH` times via `generate`.
- The table storage is flops, not SRAM, so reads are combinational.

## Test plan
1. Default table, `D_MSB_W=3`, `CONST_W=7`.
   - Stimulus: deassert `rst`; count cycles until `req_ready_o` rises. Then request ch0 with idx 4.
   - Response: ready rises after 8 cycles. One cycle after the request, ch0 outputs m_neg_1=0100110, m_neg_0=0000110, m_pos_1=1111010, m_pos_2=1011100, and `out_valid_o[0]`=1.
2. Width/depth generalisation, `D_MSB_W=4`, `CONST_W=9`.
   - Stimulus: request idx 15.
   - Response: m_pos_2 = 9'b111010100 and m_neg_1 = 9'b000110000. INIT lasts 16 cycles.
3. Config write collision.
   - Stimulus: in one cycle, write sel=1, idx=2, data=7'b0000111, and ch0 requests idx 2.
   - Response: ch0 m_neg_0 = 0000110. A ch0 re-request on the next cycle gives 0000111. The other three fields of row 2 are unchanged.
4. Multi-channel same cycle, `NUM_CH=2`.
   - Stimulus: ch0 requests idx 0, ch1 requests idx 7 in the same cycle.
   - Response: ch0 m_pos_2 = 1101000 and ch1 m_pos_2 = 1010100, both valid after 1 cycle.
   - Then ch1 idle for 10 cycles: ch1 outputs hold.
5. Reset mid-run.
   - Stimulus: after writing idx 3 sel 0 = 0111111, pulse `rst` for 1 cycle.
   - Response: outputs and valids go to 0 and ready goes to 0 for DEPTH cycles. A request to idx 3 then returns the default m_neg_1 = 0100010.
6. Requests during INIT.
   - Stimulus: hold `req_valid_i` = all 1s and `cfg_wr_valid` = 1 during INIT.
   - Response: no table change and `out_valid_o` stays 0 until RUN. The first accept happens on the first RUN cycle.

Source files
------------

// File: rtl/r4_qds_pkg.sv
// Shared types, default radix-4 QDS threshold codes and helpers.
package r4_qds_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Field select encodings for the table write port.
  localparam logic [1:0] SEL_M_NEG_1 = 2'd0;
  localparam logic [1:0] SEL_M_NEG_0 = 2'd1;
  localparam logic [1:0] SEL_M_POS_1 = 2'd2;
  localparam logic [1:0] SEL_M_POS_2 = 2'd3;

  localparam int unsigned BASE_W      = 7;
  localparam int unsigned MAX_CONST_W = 32;

  // Default 7-bit codes indexed by k (element [0] is the rightmost entry).
  localparam logic [7:0][6:0] M_NEG_1_DEF = {
    7'b0110000, 7'b0101100, 7'b0101000, 7'b0100110,
    7'b0100010, 7'b0100000, 7'b0011110, 7'b0011010};
  localparam logic [7:0][6:0] M_NEG_0_DEF = {
    7'b0001000, 7'b0001000, 7'b0001000, 7'b0000110,
    7'b0000110, 7'b0000110, 7'b0000110, 7'b0000100};
  localparam logic [7:0][6:0] M_POS_1_DEF = {
    7'b1111000, 7'b1111010, 7'b1111010, 7'b1111010,
    7'b1111100, 7'b1111100, 7'b1111100, 7'b1111100};
  localparam logic [7:0][6:0] M_POS_2_DEF = {
    7'b1010100, 7'b1010100, 7'b1011000, 7'b1011100,
    7'b1100000, 7'b1100010, 7'b1100100, 7'b1101000};

  // Default code for field sel and entry k, sign-extended to const_w bits.
  function automatic logic [MAX_CONST_W-1:0] default_const(
    input logic [1:0]  sel,
    input logic [2:0]  k,
    input int unsigned const_w
  );
    logic [BASE_W-1:0]      code;
    logic [MAX_CONST_W-1:0] ext;
    case (sel)
      SEL_M_NEG_1: code = M_NEG_1_DEF[k];
      SEL_M_NEG_0: code = M_NEG_0_DEF[k];
      SEL_M_POS_1: code = M_POS_1_DEF[k];
      default:     code = M_POS_2_DEF[k];
    endcase
    ext = {{(MAX_CONST_W-BASE_W){code[BASE_W-1]}}, code};
    for (int unsigned i = 0; i < MAX_CONST_W; i++) begin
      if (i >= const_w) ext[i] = 1'b0;
    end
    return ext;
  endfunction

endpackage

// File: rtl/r4_qds_const_rd_port.sv
// One lookup channel: accept handshake and sticky registered constants.
module r4_qds_const_rd_port #(
  parameter int unsigned CONST_W = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [CONST_W-1:0] rd_neg_1,
  input  logic [CONST_W-1:0] rd_neg_0,
  input  logic [CONST_W-1:0] rd_pos_1,
  input  logic [CONST_W-1:0] rd_pos_2,
  output logic               out_valid,
  output logic [CONST_W-1:0] m_neg_1,
  output logic [CONST_W-1:0] m_neg_0,
  output logic [CONST_W-1:0] m_pos_1,
  output logic [CONST_W-1:0] m_pos_2
);

  // Ready follows the registered RUN state of the shared table.
  assign req_ready = run;

  // Latch the addressed row on an accepted request; hold otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      m_neg_1   <= '0;
      m_neg_0   <= '0;
      m_pos_1   <= '0;
      m_pos_2   <= '0;
    end else if (req_valid && run) begin
      out_valid <= 1'b1;
      m_neg_1   <= rd_neg_1;
      m_neg_0   <= rd_neg_0;
      m_pos_1   <= rd_pos_1;
      m_pos_2   <= rd_pos_2;
    end
  end

endmodule

// File: rtl/r4_qds_const_table.sv
// Programmable radix-4 QDS threshold table with per-channel registered lookups.
module r4_qds_const_table
  import r4_qds_pkg::*;
#(
  parameter int unsigned NUM_CH  = 2,
  parameter int unsigned D_MSB_W = 3,
  parameter int unsigned CONST_W = 7
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cfg_wr_valid,
  output logic                        cfg_wr_ready,
  input  logic [D_MSB_W-1:0]          cfg_wr_idx,
  input  logic [1:0]                  cfg_wr_sel,
  input  logic [CONST_W-1:0]          cfg_wr_data,
  input  logic [NUM_CH-1:0]           req_valid_i,
  output logic [NUM_CH-1:0]           req_ready_o,
  input  logic [NUM_CH*D_MSB_W-1:0]   req_d_msbs_i,
  output logic [NUM_CH-1:0]           out_valid_o,
  output logic [NUM_CH*CONST_W-1:0]   m_neg_1_o,
  output logic [NUM_CH*CONST_W-1:0]   m_neg_0_o,
  output logic [NUM_CH*CONST_W-1:0]   m_pos_1_o,
  output logic [NUM_CH*CONST_W-1:0]   m_pos_2_o
);

  localparam int unsigned DEPTH = 2 ** D_MSB_W;
  localparam int unsigned NSEL  = 4;

  state_t             state;
  logic [D_MSB_W-1:0] row_cnt;
  logic [2:0]         init_k;
  logic [CONST_W-1:0] tbl [DEPTH][NSEL];

  // Default entry for the row being loaded: top three index bits.
  assign init_k = 3'(row_cnt >> (D_MSB_W - 3));

  // Writers are only accepted once the table is fully loaded.
  assign cfg_wr_ready = (state == ST_RUN);

  // INIT walks every row once, then RUN holds until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_INIT;
      row_cnt <= '0;
    end else if (state == ST_INIT) begin
      row_cnt <= row_cnt + D_MSB_W'(1);
      if (row_cnt == D_MSB_W'(DEPTH - 1)) begin
        state <= ST_RUN;
      end
    end
  end

  // Table storage: default load during INIT, single-field writes during RUN.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == ST_INIT) begin
        for (int unsigned s = 0; s < NSEL; s++) begin
          tbl[row_cnt][2'(s)] <= CONST_W'(default_const(2'(s), init_k, CONST_W));
        end
      end else if (cfg_wr_valid) begin
        tbl[cfg_wr_idx][cfg_wr_sel] <= cfg_wr_data;
      end
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [D_MSB_W-1:0] idx;
    assign idx = req_d_msbs_i[c*D_MSB_W +: D_MSB_W];

    r4_qds_const_rd_port #(
      .CONST_W (CONST_W)
    ) u_port (
      .clk       (clk),
      .rst       (rst),
      .run       (cfg_wr_ready),
      .req_valid (req_valid_i[c]),
      .req_ready (req_ready_o[c]),
      .rd_neg_1  (tbl[idx][SEL_M_NEG_1]),
      .rd_neg_0  (tbl[idx][SEL_M_NEG_0]),
      .rd_pos_1  (tbl[idx][SEL_M_POS_1]),
      .rd_pos_2  (tbl[idx][SEL_M_POS_2]),
      .out_valid (out_valid_o[c]),
      .m_neg_1   (m_neg_1_o[c*CONST_W +: CONST_W]),
      .m_neg_0   (m_neg_0_o[c*CONST_W +: CONST_W]),
      .m_pos_1   (m_pos_1_o[c*CONST_W +: CONST_W]),
      .m_pos_2   (m_pos_2_o[c*CONST_W +: CONST_W])
    );
  end

endmodule

// File: tb/tb_r4_qds_const_table.sv
// Directed bench for r4_qds_const_table (default 2-channel and a 4-bit/9-bit variant).
module tb_r4_qds_const_table;

  logic clk = 1'b0;
  logic rst;

  // Default-parameter instance
  logic        cfg_wr_valid, cfg_wr_ready;
  logic [2:0]  cfg_wr_idx;
  logic [1:0]  cfg_wr_sel;
  logic [6:0]  cfg_wr_data;
  logic [1:0]  req_valid, req_ready, out_valid;
  logic [5:0]  req_d;
  logic [13:0] m_neg_1, m_neg_0, m_pos_1, m_pos_2;

  // D_MSB_W=4, CONST_W=9, single-channel instance
  logic        cfg2_valid, cfg2_ready;
  logic [3:0]  cfg2_idx;
  logic [1:0]  cfg2_sel;
  logic [8:0]  cfg2_data;
  logic [0:0]  req2_valid, req2_ready, ov2;
  logic [3:0]  req2_d;
  logic [8:0]  n1_2, n0_2, p1_2, p2_2;

  int errors = 0;
  int checks = 0;
  logic [6:0] exp_neg1 [8];

  always #5 clk = ~clk;

  r4_qds_const_table #(.NUM_CH(2), .D_MSB_W(3), .CONST_W(7)) dut (
    .clk(clk), .rst(rst),
    .cfg_wr_valid(cfg_wr_valid), .cfg_wr_ready(cfg_wr_ready),
    .cfg_wr_idx(cfg_wr_idx), .cfg_wr_sel(cfg_wr_sel), .cfg_wr_data(cfg_wr_data),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_d_msbs_i(req_d),
    .out_valid_o(out_valid),
    .m_neg_1_o(m_neg_1), .m_neg_0_o(m_neg_0), .m_pos_1_o(m_pos_1), .m_pos_2_o(m_pos_2)
  );

  r4_qds_const_table #(.NUM_CH(1), .D_MSB_W(4), .CONST_W(9)) dut2 (
    .clk(clk), .rst(rst),
    .cfg_wr_valid(cfg2_valid), .cfg_wr_ready(cfg2_ready),
    .cfg_wr_idx(cfg2_idx), .cfg_wr_sel(cfg2_sel), .cfg_wr_data(cfg2_data),
    .req_valid_i(req2_valid), .req_ready_o(req2_ready), .req_d_msbs_i(req2_d),
    .out_valid_o(ov2),
    .m_neg_1_o(n1_2), .m_neg_0_o(n0_2), .m_pos_1_o(p1_2), .m_pos_2_o(p2_2)
  );

  task automatic test_reset_init();
    rst = 1'b1;
    cfg_wr_valid = 1'b0; cfg_wr_idx = '0; cfg_wr_sel = '0; cfg_wr_data = '0;
    req_valid = '0; req_d = '0;
    cfg2_valid = 1'b0; cfg2_idx = '0; cfg2_sel = '0; cfg2_data = '0;
    req2_valid = '0; req2_d = '0;
    repeat (2) @(negedge clk);
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL rst_req_ready got=%b exp=00", req_ready); end
    checks++; if (cfg_wr_ready !== 1'b0) begin errors++; $display("FAIL rst_cfg_ready got=%b exp=0", cfg_wr_ready); end
    checks++; if (out_valid !== 2'b00) begin errors++; $display("FAIL rst_out_valid got=%b exp=00", out_valid); end
    checks++; if (m_neg_1 !== 14'd0) begin errors++; $display("FAIL rst_m_neg_1 got=%h exp=0", m_neg_1); end
    checks++; if (m_pos_2 !== 14'd0) begin errors++; $display("FAIL rst_m_pos_2 got=%h exp=0", m_pos_2); end

    // Release reset while hammering requests and writes during INIT.
    rst = 1'b0;
    req_valid = 2'b11; req_d = {3'd1, 3'd5};
    cfg_wr_valid = 1'b1; cfg_wr_idx = 3'd5; cfg_wr_sel = 2'd0; cfg_wr_data = 7'h7f;
    req2_valid = 1'b1; req2_d = 4'd15;
    for (int cnt = 1; cnt <= 17; cnt++) begin
      @(negedge clk);
      checks++; if (req_ready !== ((cnt >= 8) ? 2'b11 : 2'b00)) begin errors++; $display("FAIL init_req_ready cyc=%0d got=%b", cnt, req_ready); end
      checks++; if (cfg_wr_ready !== 1'(cnt >= 8)) begin errors++; $display("FAIL init_cfg_ready cyc=%0d got=%b", cnt, cfg_wr_ready); end
      checks++; if (out_valid !== ((cnt >= 9) ? 2'b11 : 2'b00)) begin errors++; $display("FAIL init_out_valid cyc=%0d got=%b", cnt, out_valid); end
      checks++; if (req2_ready !== 1'(cnt >= 16)) begin errors++; $display("FAIL init2_ready cyc=%0d got=%b", cnt, req2_ready); end
      checks++; if (ov2 !== 1'(cnt >= 17)) begin errors++; $display("FAIL init2_valid cyc=%0d got=%b", cnt, ov2); end
      if (cnt == 8) cfg_wr_valid = 1'b0;
      if (cnt == 9) begin
        checks++; if (m_neg_1[6:0] !== 7'b0101000) begin errors++; $display("FAIL first_ch0_m_neg_1 got=%b exp=0101000", m_neg_1[6:0]); end
        checks++; if (m_neg_1[13:7] !== 7'b0011110) begin errors++; $display("FAIL first_ch1_m_neg_1 got=%b exp=0011110", m_neg_1[13:7]); end
        req_valid = 2'b00;
      end
    end
    checks++; if (p2_2 !== 9'b111010100) begin errors++; $display("FAIL w9_m_pos_2 got=%b exp=111010100", p2_2); end
    checks++; if (n1_2 !== 9'b000110000) begin errors++; $display("FAIL w9_m_neg_1 got=%b exp=000110000", n1_2); end
    req2_valid = 1'b0;
  endtask

  task automatic test_lookup_default();
    req_valid = 2'b01; req_d = {3'd0, 3'd4};
    @(negedge clk);
    req_valid = 2'b00;
    checks++; if (m_neg_1[6:0] !== 7'b0100110) begin errors++; $display("FAIL idx4_m_neg_1 got=%b exp=0100110", m_neg_1[6:0]); end
    checks++; if (m_neg_0[6:0] !== 7'b0000110) begin errors++; $display("FAIL idx4_m_neg_0 got=%b exp=0000110", m_neg_0[6:0]); end
    checks++; if (m_pos_1[6:0] !== 7'b1111010) begin errors++; $display("FAIL idx4_m_pos_1 got=%b exp=1111010", m_pos_1[6:0]); end
    checks++; if (m_pos_2[6:0] !== 7'b1011100) begin errors++; $display("FAIL idx4_m_pos_2 got=%b exp=1011100", m_pos_2[6:0]); end
    checks++; if (out_valid[0] !== 1'b1) begin errors++; $display("FAIL idx4_valid got=%b exp=1", out_valid[0]); end
  endtask

  task automatic test_collision();
    cfg_wr_valid = 1'b1; cfg_wr_idx = 3'd2; cfg_wr_sel = 2'd1; cfg_wr_data = 7'b0000111;
    req_valid = 2'b01; req_d = {3'd0, 3'd2};
    @(negedge clk);
    cfg_wr_valid = 1'b0;
    checks++; if (m_neg_0[6:0] !== 7'b0000110) begin errors++; $display("FAIL coll_old_m_neg_0 got=%b exp=0000110", m_neg_0[6:0]); end
    @(negedge clk);
    req_valid = 2'b00;
    checks++; if (m_neg_0[6:0] !== 7'b0000111) begin errors++; $display("FAIL coll_new_m_neg_0 got=%b exp=0000111", m_neg_0[6:0]); end
    checks++; if (m_neg_1[6:0] !== 7'b0100000) begin errors++; $display("FAIL coll_m_neg_1 got=%b exp=0100000", m_neg_1[6:0]); end
    checks++; if (m_pos_1[6:0] !== 7'b1111100) begin errors++; $display("FAIL coll_m_pos_1 got=%b exp=1111100", m_pos_1[6:0]); end
    checks++; if (m_pos_2[6:0] !== 7'b1100010) begin errors++; $display("FAIL coll_m_pos_2 got=%b exp=1100010", m_pos_2[6:0]); end
  endtask

  task automatic test_multi_channel();
    req_valid = 2'b11; req_d = {3'd7, 3'd0};
    @(negedge clk);
    req_valid = 2'b00;
    checks++; if (m_pos_2[6:0] !== 7'b1101000) begin errors++; $display("FAIL mc_ch0_m_pos_2 got=%b exp=1101000", m_pos_2[6:0]); end
    checks++; if (m_pos_2[13:7] !== 7'b1010100) begin errors++; $display("FAIL mc_ch1_m_pos_2 got=%b exp=1010100", m_pos_2[13:7]); end
    checks++; if (out_valid !== 2'b11) begin errors++; $display("FAIL mc_valid got=%b exp=11", out_valid); end
    // ch1 idles while row 7 is rewritten and ch0 re-reads it.
    for (int i = 0; i < 10; i++) begin
      cfg_wr_valid = (i == 0);
      cfg_wr_idx = 3'd7; cfg_wr_sel = 2'd3; cfg_wr_data = 7'b0000000;
      req_valid = (i == 2) ? 2'b01 : 2'b00;
      req_d = {3'd0, 3'd7};
      @(negedge clk);
      checks++; if (m_pos_2[13:7] !== 7'b1010100 || out_valid[1] !== 1'b1) begin errors++; $display("FAIL mc_ch1_hold cyc=%0d got=%b/%b exp=1010100/1", i, m_pos_2[13:7], out_valid[1]); end
    end
    checks++; if (m_pos_2[6:0] !== 7'b0000000) begin errors++; $display("FAIL mc_ch0_reread got=%b exp=0000000", m_pos_2[6:0]); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      req_valid = 2'b01; req_d = {3'd0, 3'(i)};
      @(negedge clk);
      checks++; if (m_neg_1[6:0] !== exp_neg1[i]) begin errors++; $display("FAIL b2b_m_neg_1 idx=%0d got=%b exp=%b", i, m_neg_1[6:0], exp_neg1[i]); end
    end
    req_valid = 2'b00;
  endtask

  task automatic test_reset_mid();
    cfg_wr_valid = 1'b1; cfg_wr_idx = 3'd3; cfg_wr_sel = 2'd0; cfg_wr_data = 7'b0111111;
    @(negedge clk);
    cfg_wr_valid = 1'b0;
    req_valid = 2'b01; req_d = {3'd0, 3'd3};
    @(negedge clk);
    req_valid = 2'b00;
    checks++; if (m_neg_1[6:0] !== 7'b0111111) begin errors++; $display("FAIL rm_written got=%b exp=0111111", m_neg_1[6:0]); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (out_valid !== 2'b00) begin errors++; $display("FAIL rm_valid got=%b exp=00", out_valid); end
    checks++; if (m_neg_1 !== 14'd0 || m_pos_2 !== 14'd0) begin errors++; $display("FAIL rm_outputs got=%h/%h exp=0/0", m_neg_1, m_pos_2); end
    checks++; if (req_ready !== 2'b00 || cfg_wr_ready !== 1'b0) begin errors++; $display("FAIL rm_ready got=%b/%b exp=00/0", req_ready, cfg_wr_ready); end
    for (int cnt = 1; cnt <= 8; cnt++) begin
      @(negedge clk);
      checks++; if (req_ready !== ((cnt >= 8) ? 2'b11 : 2'b00)) begin errors++; $display("FAIL rm_reinit_ready cyc=%0d got=%b", cnt, req_ready); end
    end
    req_valid = 2'b01; req_d = {3'd0, 3'd3};
    @(negedge clk);
    req_valid = 2'b00;
    checks++; if (m_neg_1[6:0] !== 7'b0100010) begin errors++; $display("FAIL rm_default got=%b exp=0100010", m_neg_1[6:0]); end
    checks++; if (out_valid[0] !== 1'b1) begin errors++; $display("FAIL rm_valid_after got=%b exp=1", out_valid[0]); end
  endtask

  initial begin
    exp_neg1 = '{7'b0011010, 7'b0011110, 7'b0100000, 7'b0100010,
                 7'b0100110, 7'b0101000, 7'b0101100, 7'b0110000};
    test_reset_init();
    test_lookup_default();
    test_collision();
    test_multi_channel();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
